mux_fault_checker: RTL and testbench
====================================

# mux_fault_checker

Built-in self-test sequencer for the 2:1 multiplexer under test and its 9 internal-wire taps. The block sits directly upstream of the mux and drives its `S`, `I0` and `I1` inputs. It also sits directly downstream of the mux's 9-bit `out` tap bus. It applies all 8 input patterns in order, compares the taps against a golden model and reports either a pass, or the first faulty wire together with its stuck-at value.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: clocks allowed for the mux to settle after each pattern is applied. Legal range is 1..15.

Ports:
- `clk`  in  1  the single system clock. All state is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level. Sampled only in IDLE or DONE.
- `dut_s`, `dut_i0`, `dut_i1`  out  1 each  registered drives to the mux under test.
- `dut_taps`  in  9  the mux `out` tap bus (bits 0..8).
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  high in DONE; held until the next start.
- `pass`  out  1  valid while `done` is high.
- `fault_idx`  out  4  index of the first faulty wire.
- `stuck_val`  out  1  stuck-at value of the faulty wire, equal to the inverse of its golden value.
- `fail_pattern`  out  3  pattern index at which the fault was detected, encoded as {I0,I1,S}.

## Operation
- Pattern index `p` runs 0..7. `dut_i0` = p[2], `dut_i1` = p[1], `dut_s` = p[0].
- Golden value for each tap:
  - 0 = I0
  - 1 = I1
  - 2, 3, 4 = S
  - 5 = ~S
  - 6 = I1&S
  - 7 = I0&~S
  - 8 = (I1&S)|(I0&~S)
- FSM states and transitions:
  - IDLE, on `start`: clear all results. Set p = 0 and drive pattern 0. Load the settle counter with SETTLE_CYCLES-1. Go to SETTLE.
  - SETTLE: decrement the counter. When the counter reads 0, go to CHECK.
  - CHECK: compute mismatch = `dut_taps` ^ golden(p).
    - If mismatch ≠ 0: capture `fault_idx` = lowest set bit, `stuck_val` = ~golden[fault_idx], `fail_pattern` = p, `pass` = 0. Go to DONE.
    - Else if p == 7: set `pass` = 1. Go to DONE.
    - Else: increment p, drive the new pattern, reload the counter. Go to SETTLE.
  - DONE: `done` = 1, `busy` = 0. A `start` here behaves exactly like `start` in IDLE, and `done` drops on the following edge.
- `start` in SETTLE or CHECK is ignored.
- `dut_*` hold the last applied pattern through DONE.
- When several taps mismatch, only the lowest index is reported.

## Timing
- Every output resets to 0 immediately on `rst_n` low, in every state. After reset the FSM is in IDLE and p = 0.
- Each pattern costs SETTLE_CYCLES+1 clocks.
- Runs that pass: `done` rises (SETTLE_CYCLES+1)×8 edges after the edge that sampled `start`. This is 24 with the default.
- Runs that fail at pattern k: `done` rises (SETTLE_CYCLES+1)×(k+1) edges after that edge.
- `busy` rises on the edge that samples `start`. It falls on the same edge that raises `done`.
- Result outputs update only on the CHECK→DONE edge and are stable throughout DONE.
- `dut_taps` is sampled only in CHECK. The value present in SETTLE is don't-care.
- Reset asserted mid-run aborts the run with no result. Results from any previous run are also lost.

## Structure
- Package `mux_fault_pkg` holds:
  - `NUM_TAPS` = 9
  - the tap index constants
  - the FSM state enum
  - the pattern bit-order constants
- Sub-module `mux_golden_model`: combinational. Maps (S, I0, I1) to the 9-bit golden vector. The bench reuses it as the fault-free mux model.
- The lowest-set-bit encoder is a function in the package.

## Test plan
- Fault-free taps (driven from `mux_golden_model`), `start` pulse → `done` at edge 24, `pass` = 1, `fault_idx` = 0, `busy` high for exactly 24 cycles.
- Tap 8 forced to 0 → first fails at p = 3 (I0=0, I1=1, S=1). `done` at edge 12, `pass` = 0, `fault_idx` = 8, `stuck_val` = 0, `fail_pattern` = 3.
- Tap 5 forced to 1 → fails at p = 1. `done` at edge 6, `fault_idx` = 5, `stuck_val` = 1, `fail_pattern` = 1.
- Taps 0 and 2 both forced to 1 → fails at p = 0. `done` at edge 3, `fault_idx` = 0 (lowest index wins), `stuck_val` = 1.
- `rst_n` pulsed low while p = 4 → all outputs 0 in the same cycle. After release, `start` → a full fault-free run, `done` at edge 24.
- `start` held high across a whole run: it is ignored while busy. In DONE the next edge restarts the run, `done` drops, and `busy` rises.

Source files
------------

// File: rtl/mux_fault_pkg.sv
// mux_fault_pkg
// Shared definitions for the 2:1 mux built-in self-test sequencer:
//   - NUM_TAPS and the index of every internal-wire tap of the mux
//   - bit positions of S, I1 and I0 inside the 3-bit pattern index
//   - the sequencer FSM state encoding
//   - lowest_set_idx(): priority encoder used to pick the first faulty tap
package mux_fault_pkg;

   localparam int NUM_TAPS = 9;

   // Tap indices on the mux 'out' bus
   localparam int TAP_I0    = 0;   // I0 input wire
   localparam int TAP_I1    = 1;   // I1 input wire
   localparam int TAP_S_A   = 2;   // S fan-out branch A
   localparam int TAP_S_B   = 3;   // S fan-out branch B
   localparam int TAP_S_C   = 4;   // S fan-out branch C
   localparam int TAP_S_N   = 5;   // inverted select
   localparam int TAP_AND_1 = 6;   // I1 & S
   localparam int TAP_AND_0 = 7;   // I0 & ~S
   localparam int TAP_OUT   = 8;   // final OR output

   // Pattern index p is {I0, I1, S}
   localparam int PAT_S_BIT  = 0;
   localparam int PAT_I1_BIT = 1;
   localparam int PAT_I0_BIT = 2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_CHECK  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Index of the lowest set bit; returns 0 when no bit is set
   function automatic logic [3:0] lowest_set_idx(input logic [NUM_TAPS-1:0] vec);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = NUM_TAPS - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = 4'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/mux_fault_checker_golden.sv
// mux_golden_model
// Combinational fault-free model of the 2:1 mux and its 9 internal taps.
// Ports:
//   s, i0, i1  in  1  mux select and data inputs
//   golden     out 9  expected value of every tap (index per mux_fault_pkg)
module mux_golden_model
   import mux_fault_pkg::*;
(
   input  logic                s,
   input  logic                i0,
   input  logic                i1,
   output logic [NUM_TAPS-1:0] golden
);

   // Expected value of every tap for the applied pattern
   always_comb begin
      golden            = '0;
      golden[TAP_I0]    = i0;
      golden[TAP_I1]    = i1;
      golden[TAP_S_A]   = s;
      golden[TAP_S_B]   = s;
      golden[TAP_S_C]   = s;
      golden[TAP_S_N]   = ~s;
      golden[TAP_AND_1] = i1 & s;
      golden[TAP_AND_0] = i0 & ~s;
      golden[TAP_OUT]   = (i1 & s) | (i0 & ~s);
   end

endmodule

// File: rtl/mux_fault_checker.sv
// mux_fault_checker
// Self-test sequencer for a 2:1 mux: applies the 8 input patterns in order,
// waits SETTLE_CYCLES clocks per pattern, compares the 9 tap wires against
// the golden model and reports pass or the first faulty tap.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 level request, sampled in IDLE or DONE
//   dut_s/dut_i0/dut_i1   registered drives to the mux under test
//   dut_taps[8:0]         mux internal tap bus
//   busy, done            run in progress / result valid
//   pass, fault_idx, stuck_val, fail_pattern  result of the last run
module mux_fault_checker
   import mux_fault_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   output logic                dut_s,
   output logic                dut_i0,
   output logic                dut_i1,
   input  logic [NUM_TAPS-1:0] dut_taps,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [3:0]          fault_idx,
   output logic                stuck_val,
   output logic [2:0]          fail_pattern
);

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   state_t                state_r;
   logic [2:0]            pat_r;
   logic [3:0]            cnt_r;
   logic                  busy_r;
   logic                  done_r;
   logic                  pass_r;
   logic [3:0]            fault_idx_r;
   logic                  stuck_val_r;
   logic [2:0]            fail_pattern_r;
   logic [NUM_TAPS-1:0]   golden_s;
   logic [NUM_TAPS-1:0]   mismatch_s;
   logic [3:0]            first_s;

   // Golden taps follow the pattern currently driven onto the mux
   mux_golden_model u_golden (
      .s      (pat_r[PAT_S_BIT]),
      .i0     (pat_r[PAT_I0_BIT]),
      .i1     (pat_r[PAT_I1_BIT]),
      .golden (golden_s)
   );

   // Tap comparison and first-fault selection
   always_comb begin
      mismatch_s = dut_taps ^ golden_s;
      first_s    = lowest_set_idx(mismatch_s);
   end

   // Sequencer FSM with registered drives and results
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r        <= ST_IDLE;
         pat_r          <= 3'd0;
         cnt_r          <= 4'd0;
         busy_r         <= 1'b0;
         done_r         <= 1'b0;
         pass_r         <= 1'b0;
         fault_idx_r    <= 4'd0;
         stuck_val_r    <= 1'b0;
         fail_pattern_r <= 3'd0;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_r        <= ST_SETTLE;
                  pat_r          <= 3'd0;
                  cnt_r          <= SETTLE_LOAD;
                  busy_r         <= 1'b1;
                  done_r         <= 1'b0;
                  pass_r         <= 1'b0;
                  fault_idx_r    <= 4'd0;
                  stuck_val_r    <= 1'b0;
                  fail_pattern_r <= 3'd0;
               end else begin
                  state_r <= state_r;
               end
            end
            ST_SETTLE: begin
               if (cnt_r == 4'd0) begin
                  state_r <= ST_CHECK;
               end else begin
                  cnt_r <= cnt_r - 4'd1;
               end
            end
            ST_CHECK: begin
               if (mismatch_s != '0) begin
                  state_r        <= ST_DONE;
                  busy_r         <= 1'b0;
                  done_r         <= 1'b1;
                  pass_r         <= 1'b0;
                  fault_idx_r    <= first_s;
                  // the wire is stuck at the opposite of what it should read
                  stuck_val_r    <= ~golden_s[first_s];
                  fail_pattern_r <= pat_r;
               end else if (pat_r == 3'd7) begin
                  state_r <= ST_DONE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  pass_r  <= 1'b1;
               end else begin
                  state_r <= ST_SETTLE;
                  pat_r   <= pat_r + 3'd1;
                  cnt_r   <= SETTLE_LOAD;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign dut_s        = pat_r[PAT_S_BIT];
   assign dut_i1       = pat_r[PAT_I1_BIT];
   assign dut_i0       = pat_r[PAT_I0_BIT];
   assign busy         = busy_r;
   assign done         = done_r;
   assign pass         = pass_r;
   assign fault_idx    = fault_idx_r;
   assign stuck_val    = stuck_val_r;
   assign fail_pattern = fail_pattern_r;

endmodule

// File: tb/tb_mux_fault_checker.sv
// tb_mux_fault_checker
// Self-checking bench: the mux under test is the golden model with optional
// stuck-at-0/1 masks on its taps; expected results come from a bench-side
// pattern walk computed directly from the mux equations.
module tb_mux_fault_checker;

   localparam int SETTLE = 2;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       dut_s, dut_i0, dut_i1;
   logic [8:0] dut_taps;
   logic       busy, done, pass, stuck_val;
   logic [3:0] fault_idx;
   logic [2:0] fail_pattern;
   logic [8:0] gold_dut;
   logic [8:0] stuck0, stuck1;
   logic       gs, gi0, gi1;
   logic [8:0] gold_ref;

   int checks = 0;
   int errors = 0;

   mux_fault_checker #(.SETTLE_CYCLES(SETTLE)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .dut_s(dut_s), .dut_i0(dut_i0), .dut_i1(dut_i1),
      .dut_taps(dut_taps), .busy(busy), .done(done), .pass(pass),
      .fault_idx(fault_idx), .stuck_val(stuck_val), .fail_pattern(fail_pattern)
   );

   // Fault-free mux model driven by the checker
   mux_golden_model u_mux (.s(dut_s), .i0(dut_i0), .i1(dut_i1), .golden(gold_dut));
   // Second copy driven directly by the bench for an exhaustive table check
   mux_golden_model u_ref (.s(gs), .i0(gi0), .i1(gi1), .golden(gold_ref));

   // Stuck-at-1 wins over stuck-at-0 when both are set on a tap
   assign dut_taps = (gold_dut & ~stuck0) | stuck1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Tap values of a healthy mux for pattern p = {I0,I1,S}
   function automatic logic [8:0] ref_gold(input int p);
      int s, i1, i0, o;
      logic [8:0] g;
      s  = p % 2;
      i1 = (p / 2) % 2;
      i0 = (p / 4) % 2;
      o  = (s == 1) ? i1 : i0;
      g  = 9'd0;
      g[0] = i0[0];
      g[1] = i1[0];
      g[2] = s[0];
      g[3] = s[0];
      g[4] = s[0];
      g[5] = (s == 0);
      g[6] = (i1 == 1 && s == 1);
      g[7] = (i0 == 1 && s == 0);
      g[8] = o[0];
      return g;
   endfunction

   // Walk the 8 patterns and predict the outcome of a run
   task automatic predict(input logic [8:0] m0, input logic [8:0] m1,
                          output bit e_pass, output int e_idx, output int e_sv,
                          output int e_pat, output int e_edges);
      logic [8:0] g, mis;
      bit found;
      found   = 1'b0;
      e_pass  = 1'b1;
      e_idx   = 0;
      e_sv    = 0;
      e_pat   = 7;
      e_edges = (SETTLE + 1) * 8;
      for (int p = 0; p < 8; p++) begin
         g   = ref_gold(p);
         mis = ((g & ~m0) | m1) ^ g;
         if (!found && mis != 9'd0) begin
            found  = 1'b1;
            e_pass = 1'b0;
            e_pat  = p;
            e_edges = (SETTLE + 1) * (p + 1);
            for (int i = 8; i >= 0; i--) begin
               if (mis[i]) e_idx = i;
            end
            e_sv = g[e_idx] ? 0 : 1;
         end
      end
   endtask

   // Wait for done after the start-sampling edge; returns edges taken and busy cycles
   task automatic wait_done(output int n, output int busy_cnt);
      bit got;
      got = 1'b0;
      n = 0;
      busy_cnt = busy ? 1 : 0;
      while (!got && n < 200) begin
         @(posedge clk); #1;
         n++;
         if (done) got = 1'b1;
         else if (busy) busy_cnt++;
      end
      check_eq("done_seen", 32'(got), 32'd1);
   endtask

   task automatic run_case(input string tag, input logic [8:0] m0, input logic [8:0] m1);
      bit e_pass;
      int e_idx, e_sv, e_pat, e_edges, n, bc;
      stuck0 = m0;
      stuck1 = m1;
      predict(m0, m1, e_pass, e_idx, e_sv, e_pat, e_edges);
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      check_eq({tag, "_busy_rise"}, 32'(busy), 32'd1);
      check_eq({tag, "_done_low"}, 32'(done), 32'd0);
      wait_done(n, bc);
      check_eq({tag, "_done_edge"}, 32'(n), 32'(e_edges));
      check_eq({tag, "_busy_cycles"}, 32'(bc), 32'(e_edges));
      check_eq({tag, "_busy_fall"}, 32'(busy), 32'd0);
      check_eq({tag, "_pass"}, 32'(pass), 32'(e_pass));
      check_eq({tag, "_fault_idx"}, 32'(fault_idx), 32'(e_idx));
      check_eq({tag, "_stuck_val"}, 32'(stuck_val), 32'(e_sv));
      check_eq({tag, "_fail_pat"}, 32'(fail_pattern), e_pass ? 32'd0 : 32'(e_pat));
      check_eq({tag, "_drive_hold"}, 32'({dut_i0, dut_i1, dut_s}), 32'(e_pat));
      repeat (3) @(posedge clk);
      #1;
      check_eq({tag, "_done_stable"}, 32'(done), 32'd1);
      check_eq({tag, "_result_stable"}, 32'({pass, fault_idx, stuck_val}),
               32'({e_pass, 4'(e_idx), 1'(e_sv)}));
   endtask

   initial begin
      int n, bc, k, a, b;
      rst_n  = 1'b0;
      start  = 1'b0;
      stuck0 = 9'd0;
      stuck1 = 9'd0;
      gs = 1'b0; gi0 = 1'b0; gi1 = 1'b0;

      // Golden model table against the mux equations
      for (int p = 0; p < 8; p++) begin
         gs = p[0]; gi1 = p[1]; gi0 = p[2];
         #1;
         check_eq($sformatf("gold_p%0d", p), 32'(gold_ref), 32'(ref_gold(p)));
      end

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset_outs", 32'({busy, done, pass, fault_idx, stuck_val, fail_pattern,
                                  dut_s, dut_i0, dut_i1}), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check_eq("idle_outs", 32'({busy, done, pass, fault_idx}), 32'd0);

      // Directed cases
      run_case("clean", 9'd0, 9'd0);
      run_case("t8_sa0", 9'h100, 9'd0);
      run_case("t5_sa1", 9'd0, 9'h020);
      run_case("t0t2_sa1", 9'd0, 9'h005);

      // Reset in the middle of pattern 4
      stuck0 = 9'd0; stuck1 = 9'd0;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat ((SETTLE + 1) * 4 + 1) @(posedge clk);
      #1;
      check_eq("midrun_pat4", 32'({dut_i0, dut_i1, dut_s}), 32'd4);
      check_eq("midrun_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("async_reset_outs", 32'({busy, done, pass, fault_idx, stuck_val, fail_pattern,
                                        dut_s, dut_i0, dut_i1}), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      run_case("after_reset", 9'd0, 9'd0);

      // start held high through a whole run and into DONE
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1;
      wait_done(n, bc);
      check_eq("held_done_edge", 32'(n), 32'((SETTLE + 1) * 8));
      check_eq("held_pass", 32'(pass), 32'd1);
      @(posedge clk); #1;
      check_eq("held_restart_done", 32'(done), 32'd0);
      check_eq("held_restart_busy", 32'(busy), 32'd1);
      wait_done(n, bc);
      start = 1'b0;
      check_eq("held_second_edge", 32'(n), 32'((SETTLE + 1) * 8));
      check_eq("held_second_busy", 32'(bc), 32'((SETTLE + 1) * 8));

      // Randomized fault injection
      for (int r = 0; r < 12; r++) begin
         k = $urandom_range(0, 3);
         a = $urandom_range(0, 8);
         b = $urandom_range(0, 8);
         case (k)
            0: run_case($sformatf("rnd%0d", r), 9'd0, 9'd0);
            1: run_case($sformatf("rnd%0d", r), 9'(1 << a), 9'd0);
            2: run_case($sformatf("rnd%0d", r), 9'd0, 9'(1 << a));
            default: run_case($sformatf("rnd%0d", r), 9'(1 << a), 9'(1 << b));
         endcase
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
